imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the instruction memory from a byte stream before the datapath runs. A host presents program bytes over a valid/ready handshake. The block packs them big-endian into 32-bit instruction words, writes them to sequential word addresses, and holds the datapath in reset until the load completes. It is the write-side counterpart of the instruction memory read port, which is indexed by `pc[7:2]`.

## Interface
- `ADDR_WIDTH`, 6, instruction memory word-address width (64 words).
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `start`  in  1  load request; honoured only in IDLE.
- `num_words`  in  ADDR_WIDTH+1  words to load; sampled with `start`.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_wenable`  out  1  instruction memory write strobe.
- `mem_waddr`  out  ADDR_WIDTH  word address of the write.
- `mem_wdata`  out  32  instruction word.
- `cpu_reset`  out  1  active-high reset to the datapath `pcreg`.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when the load finishes.
- `word_count`  out  ADDR_WIDTH+1  words written since the last `start`.

## Operation
- States: IDLE, RECV, WRITE, DONE. All outputs are registered or decoded from state only.
- Length clamp: on `start` in IDLE, latch `len = min(num_words, 2**ADDR_WIDTH)`. Clear `word_count`, the byte index and the address to 0.
- IDLE → DONE if `start && len == 0`. No writes occur.
- IDLE → RECV if `start && len != 0`.
- RECV: `in_ready = 1`. A byte is accepted when `in_valid && in_ready` at a rising edge.
- Byte packing: byte index 0 goes to `[31:24]`, 1 to `[23:16]`, 2 to `[15:8]`, 3 to `[7:0]`.
- RECV → WRITE on acceptance of byte index 3. The byte index wraps to 0.
- WRITE lasts exactly 1 cycle:
  - `mem_wenable = 1`, `mem_waddr` = current address, `mem_wdata` = packed word, `in_ready = 0`.
  - At the end of the cycle, `word_count` and the address increment.
- WRITE → DONE if the incremented `word_count == len`, else WRITE → RECV.
- DONE lasts 1 cycle with `done = 1`, then → IDLE.
- `busy = 1` in RECV, WRITE and DONE.
- `cpu_reset = 1` in RECV, WRITE and DONE. It drops to 0 in the cycle the FSM enters IDLE.
- `start` while not in IDLE is ignored. `num_words` is not re-sampled.
- `in_valid` in IDLE, WRITE or DONE: the byte is not consumed (`in_ready = 0`). The host must hold it.
- Address wrap: a full 64-word load writes addresses 0..63. The address register may wrap to 0 after the last write; no write follows.
- `mem_waddr` and `mem_wdata` hold their last values outside WRITE. Only `mem_wenable` qualifies them.

## Timing
- Reset (`reset == 0` at an edge) forces, from the following cycle:
  - state IDLE;
  - `in_ready`, `mem_wenable`, `busy`, `done`, `cpu_reset` = 0;
  - `word_count` = 0, `mem_waddr` = 0, `mem_wdata` = 0;
  - byte index 0.
- Reset mid-load aborts immediately. Partially assembled bytes are discarded. Already-written words remain in memory. No `done` pulse is produced.
- Reset takes priority over `start` and over the handshake in the same cycle.
- Latency:
  - 4th byte accepted at edge N → `mem_wenable` high during cycle N..N+1. The memory captures the word at edge N+1.
  - Last WRITE at edge M → `done` high during cycle M..M+1. `cpu_reset` low from edge M+1.
- Throughput: at most one byte per cycle. Minimum 5 cycles per word (4 RECV + 1 WRITE) with `in_valid` held high.
- `start` at edge S with `len > 0` → `in_ready` and `cpu_reset` high from edge S.

## Test plan
- Reset: hold `reset = 0` for 2 cycles with random inputs → all outputs 0, state IDLE; `in_ready` stays 0 under `in_valid = 1`.
- Single word:
  - Stimulus: `start`, `num_words = 1`, bytes 0x20,0x0A,0x00,0x02 back-to-back.
  - Required: one `mem_wenable` pulse with `mem_waddr = 0`, `mem_wdata = 0x200A0002`; `done` 1 cycle later; `word_count = 1`; `cpu_reset` falls the cycle after `done`.
- Backpressure/gaps:
  - Stimulus: 3 words with `in_valid` toggled randomly.
  - Required: writes to addresses 0,1,2 with correctly packed data; no byte lost or duplicated; `in_ready` low during each WRITE cycle.
- Length edges:
  - `num_words = 0` → `done` the cycle after `start`, no `mem_wenable`.
  - `num_words = 100` → exactly 64 writes to addresses 0..63, then `done`.
- Mid-load abort:
  - Stimulus: `reset = 0` after 2 bytes of word 1, then a fresh 1-word load of 0xDEADBEEF.
  - Required: no `done` for the aborted load; the new word is written at address 0.
- Ignored start: pulse `start` with `num_words = 5` during RECV of a 2-word load → exactly 2 writes, `word_count = 2`.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader: packs a big-endian host byte stream into 32-bit words, writes them to
// sequential instruction memory addresses, and holds the datapath in reset while loading.
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_wenable,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   clamped_len;
    logic [ADDR_WIDTH:0]   next_count;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            byte_idx;
    logic [23:0]           pack;
    logic                  accept;

    assign clamped_len = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    assign next_count  = word_count + (ADDR_WIDTH + 1)'(1);
    assign accept      = (state == RECV) && in_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        mem_wenable = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cpu_reset   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (clamped_len == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                in_ready  = 1'b1;
                busy      = 1'b1;
                cpu_reset = 1'b1;
                if (accept && byte_idx == 2'd3) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                mem_wenable = 1'b1;
                busy        = 1'b1;
                cpu_reset   = 1'b1;
                next_state  = (next_count == len) ? DONE : RECV;
            end
            DONE: begin
                done       = 1'b1;
                busy       = 1'b1;
                cpu_reset  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The write port registers are loaded with the 4th byte so they are stable for the whole WRITE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len        <= '0;
            addr       <= '0;
            byte_idx   <= '0;
            pack       <= '0;
            word_count <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len        <= clamped_len;
                        addr       <= '0;
                        byte_idx   <= '0;
                        word_count <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: pack[23:16] <= in_data;
                            2'd1: pack[15:8]  <= in_data;
                            2'd2: pack[7:0]   <= in_data;
                            default: begin
                                mem_wdata <= {pack, in_data};
                                mem_waddr <= addr;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_count <= next_count;
                    addr       <= addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: reset, single word, gaps, length edges, abort, ignored start.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  num_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wenable;
    logic [5:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [6:0]  word_count;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int ready_in_write = 0;
    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.ADDR_WIDTH(6)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_words(num_words),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_wenable(mem_wenable),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .busy(busy),
        .done(done),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every memory write and done pulse mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_wenable === 1'b1) begin
            wr_addr.push_back(mem_waddr);
            wr_data.push_back(mem_wdata);
            if (in_ready !== 1'b0) ready_in_write++;
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic start_load(input logic [6:0] n);
        start = 1'b1;
        num_words = n;
        step();
        start = 1'b0;
        num_words = 7'h7F;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        bit got;
        waited = 0;
        got = 0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data = b;
        while (!got && waited < 50) begin
            @(negedge clk);
            if (in_ready === 1'b1) got = 1;
            else waited++;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("[TB] FAIL handshake: byte %h not accepted, waited %0d cycles, required acceptance", b, waited);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL done_timeout: done=0 after %0d cycles, required 1", budget);
        end
    endtask

    function automatic logic [31:0] full_word(input int i);
        return {8'(i), 8'(~i), 8'(i + 64), 8'hC3};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            start = 1'($urandom_range(0, 1));
            num_words = 7'($urandom);
            in_data = 8'($urandom);
            step();
        end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
        vectors++; if (mem_wenable !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wenable: got %b want 0", mem_wenable); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done: got %b want 0", done); end
        vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cpu_reset: got %b want 0", cpu_reset); end
        vectors++; if (word_count !== 7'd0) begin miscompares++; $display("[TB] FAIL rst_word_count: got %0d want 0", word_count); end
        vectors++; if (mem_waddr !== 6'd0) begin miscompares++; $display("[TB] FAIL rst_waddr: got %0d want 0", mem_waddr); end
        vectors++; if (mem_wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_wdata: got %h want 0", mem_wdata); end
        reset = 1'b1;
        start = 1'b0;
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_in_ready: got %b want 0 with in_valid=1", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_single_word();
        clear_log();
        start_load(7'd1);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_ready_at_start: got %b want 1", in_ready); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_cpu_reset_at_start: got %b want 1", cpu_reset); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_busy: got %b want 1", busy); end
        send_byte(8'h20, 0);
        send_byte(8'h0A, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        vectors++; if (mem_wenable !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_wenable: got %b want 1", mem_wenable); end
        vectors++; if (mem_waddr !== 6'd0) begin miscompares++; $display("[TB] FAIL sw_waddr: got %0d want 0", mem_waddr); end
        vectors++; if (mem_wdata !== 32'h200A0002) begin miscompares++; $display("[TB] FAIL sw_wdata: got %h want 200a0002", mem_wdata); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_ready_in_write: got %b want 0", in_ready); end
        step();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_done: got %b want 1", done); end
        vectors++; if (word_count !== 7'd1) begin miscompares++; $display("[TB] FAIL sw_word_count: got %0d want 1", word_count); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_cpu_reset_in_done: got %b want 1", cpu_reset); end
        vectors++; if (mem_wenable !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_wenable_in_done: got %b want 0", mem_wenable); end
        vectors++; if (mem_wdata !== 32'h200A0002) begin miscompares++; $display("[TB] FAIL sw_wdata_hold: got %h want 200a0002", mem_wdata); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_done_pulse: got %b want 0", done); end
        vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_cpu_reset_fall: got %b want 0", cpu_reset); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_busy_fall: got %b want 0", busy); end
        vectors++; if (wr_addr.size() != 1) begin miscompares++; $display("[TB] FAIL sw_write_count: got %0d want 1", wr_addr.size()); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        bit seen;
        w[0] = 32'h11223344;
        w[1] = 32'hA5B6C7D8;
        w[2] = 32'h0F1E2D3C;
        clear_log();
        ready_in_write = 0;
        start_load(7'd3);
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(w[i][(31 - 8 * b) -: 8], $urandom_range(0, 2));
            end
        end
        wait_done(40, seen);
        if (seen) begin
            vectors++; if (word_count !== 7'd3) begin miscompares++; $display("[TB] FAIL bp_word_count: got %0d want 3", word_count); end
        end
        step();
        vectors++; if (wr_addr.size() != 3) begin miscompares++; $display("[TB] FAIL bp_write_count: got %0d want 3", wr_addr.size()); end
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            vectors++; if (wr_addr[i] !== 6'(i)) begin miscompares++; $display("[TB] FAIL bp_addr%0d: got %0d want %0d", i, wr_addr[i], i); end
            vectors++; if (wr_data[i] !== w[i]) begin miscompares++; $display("[TB] FAIL bp_data%0d: got %h want %h", i, wr_data[i], w[i]); end
        end
        vectors++; if (ready_in_write != 0) begin miscompares++; $display("[TB] FAIL bp_ready_in_write: got %0d cycles want 0", ready_in_write); end
    endtask

    task automatic test_length_edges();
        bit seen;
        clear_log();
        start_load(7'd0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL len0_done: got %b want 1", done); end
        vectors++; if (word_count !== 7'd0) begin miscompares++; $display("[TB] FAIL len0_word_count: got %0d want 0", word_count); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL len0_done_pulse: got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL len0_busy: got %b want 0", busy); end
        vectors++; if (wr_addr.size() != 0) begin miscompares++; $display("[TB] FAIL len0_writes: got %0d want 0", wr_addr.size()); end

        clear_log();
        start_load(7'd100);
        for (int i = 0; i < 64; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(full_word(i)[(31 - 8 * b) -: 8], 0);
            end
        end
        wait_done(10, seen);
        if (seen) begin
            vectors++; if (word_count !== 7'd64) begin miscompares++; $display("[TB] FAIL len100_word_count: got %0d want 64", word_count); end
        end
        step();
        step();
        vectors++; if (wr_addr.size() != 64) begin miscompares++; $display("[TB] FAIL len100_writes: got %0d want 64", wr_addr.size()); end
        for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
            vectors++; if (wr_addr[i] !== 6'(i)) begin miscompares++; $display("[TB] FAIL len100_addr%0d: got %0d want %0d", i, wr_addr[i], i); end
            vectors++; if (wr_data[i] !== full_word(i)) begin miscompares++; $display("[TB] FAIL len100_data%0d: got %h want %h", i, wr_data[i], full_word(i)); end
        end
        vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL len100_cpu_reset: got %b want 0", cpu_reset); end
    endtask

    task automatic test_mid_load_abort();
        int d;
        bit seen;
        clear_log();
        start_load(7'd2);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h0D, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        d = done_cnt;
        reset = 1'b0;
        start = 1'b1;
        num_words = 7'd1;
        in_valid = 1'b1;
        in_data = 8'h55;
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_in_ready: got %b want 0", in_ready); end
        vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_cpu_reset: got %b want 0", cpu_reset); end
        vectors++; if (word_count !== 7'd0) begin miscompares++; $display("[TB] FAIL abort_word_count: got %0d want 0", word_count); end
        vectors++; if (mem_waddr !== 6'd0) begin miscompares++; $display("[TB] FAIL abort_waddr: got %0d want 0", mem_waddr); end
        vectors++; if (mem_wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL abort_wdata: got %h want 0", mem_wdata); end
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        vectors++; if (done_cnt != d) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", done_cnt - d); end
        start_load(7'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        wait_done(5, seen);
        step();
        vectors++; if (done_cnt != d + 1) begin miscompares++; $display("[TB] FAIL abort_reload_done: got %0d pulses want 1", done_cnt - d); end
        vectors++; if (wr_addr.size() != 2) begin miscompares++; $display("[TB] FAIL abort_writes: got %0d want 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            vectors++; if (wr_data[0] !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL abort_first_data: got %h want cafef00d", wr_data[0]); end
            vectors++; if (wr_addr[1] !== 6'd0) begin miscompares++; $display("[TB] FAIL abort_reload_addr: got %0d want 0", wr_addr[1]); end
            vectors++; if (wr_data[1] !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL abort_reload_data: got %h want deadbeef", wr_data[1]); end
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] w [2];
        bit seen;
        w[0] = 32'h01020304;
        w[1] = 32'h05060708;
        clear_log();
        start_load(7'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        start = 1'b1;
        num_words = 7'd5;
        step();
        start = 1'b0;
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        for (int b = 0; b < 4; b++) send_byte(w[1][(31 - 8 * b) -: 8], 0);
        wait_done(10, seen);
        if (seen) begin
            vectors++; if (word_count !== 7'd2) begin miscompares++; $display("[TB] FAIL ign_word_count: got %0d want 2", word_count); end
        end
        step();
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_busy: got %b want 0", busy); end
        vectors++; if (wr_addr.size() != 2) begin miscompares++; $display("[TB] FAIL ign_writes: got %0d want 2", wr_addr.size()); end
        for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
            vectors++; if (wr_addr[i] !== 6'(i)) begin miscompares++; $display("[TB] FAIL ign_addr%0d: got %0d want %0d", i, wr_addr[i], i); end
            vectors++; if (wr_data[i] !== w[i]) begin miscompares++; $display("[TB] FAIL ign_data%0d: got %h want %h", i, wr_data[i], w[i]); end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        num_words = '0;
        in_valid = 1'b0;
        in_data = '0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_length_edges();
        test_mid_load_abort();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
